// File: rtl/ifu_pkg.sv
// IFU shared package: next-PC select encodings, exception codes and
// the default address map of the instruction fetch unit.
package ifu_pkg;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  localparam logic [31:0] PC_RESET_DEF  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;
  localparam logic [31:0] IM_LO_DEF     = 32'h0000_3000;
  localparam logic [31:0] IM_HI_DEF     = 32'h0000_6FFC;

  // Fetch address error: misaligned or outside the instruction memory.
  function automatic logic adel_chk(
    input logic [31:0] pc,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction

endpackage

// File: rtl/ifu_if.sv
// D-stage redirect bundle: control-flow and exception inputs that steer
// the fetch unit's next-PC selection.
interface ifu_if;

    logic        req;
    logic        en;
    logic        eret;
    logic        br_taken;
    logic [1:0]  npc_sel;
    logic [31:0] d_pc;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs;
    logic [31:0] epc;

    modport master (
        output req, en, eret, br_taken, npc_sel,
        output d_pc, imm16, imm26, rs, epc
    );

    modport slave (
        input req, en, eret, br_taken, npc_sel,
        input d_pc, imm16, imm26, rs, epc
    );

endinterface

// File: rtl/ifu_npc.sv
// Next-PC selection: exception redirect, stall hold, eret, branch, jump,
// register jump, then sequential fetch, in that priority order.
module ifu_npc
    import ifu_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF
) (
    ifu_if.slave        d,
    input  logic [31:0] pc_i,
    output logic [31:0] npc_o,
    output logic        eret_sel_o
);

    logic [31:0] br_off;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;

    assign br_off = {{14{d.imm16[15]}}, d.imm16, 2'b00};
    assign br_tgt = d.d_pc + 32'd4 + br_off;
    assign j_tgt  = {d.d_pc[31:28], d.imm26, 2'b00};

    always_comb begin
        npc_o      = pc_i + 32'd4;
        eret_sel_o = 1'b0;
        if (d.req) begin
            npc_o = EXC_ENTRY;
        end else if (d.en) begin
            npc_o = pc_i;
        end else if (d.eret) begin
            npc_o      = d.epc;
            eret_sel_o = 1'b1;
        end else begin
            case (d.npc_sel)
                NPC_BR: if (d.br_taken) npc_o = br_tgt;
                NPC_J:  npc_o = j_tgt;
                NPC_JR: npc_o = d.rs;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, eret delay-slot squash, fetch
// address check and the F-stage outputs toward the F/D register.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF,
    parameter logic [31:0] IM_LO     = IM_LO_DEF,
    parameter logic [31:0] IM_HI     = IM_HI_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Req,
    input  logic        _en,
    input  logic [1:0]  D_npc_sel,
    input  logic        D_br_taken,
    input  logic [31:0] D_PC,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_imm26,
    input  logic [31:0] D_rs,
    input  logic        D_eret,
    input  logic [31:0] EPC,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] F_IR,
    output logic [4:0]  F_EXC,
    output logic        F_BD
);

    logic [31:0] pc_q, pc_d;
    logic        squash_q, squash_d;
    logic        eret_sel;
    logic        adel;

    ifu_if nif ();

    assign nif.req      = Req;
    assign nif.en       = _en;
    assign nif.eret     = D_eret;
    assign nif.br_taken = D_br_taken;
    assign nif.npc_sel  = D_npc_sel;
    assign nif.d_pc     = D_PC;
    assign nif.imm16    = D_imm16;
    assign nif.imm26    = D_imm26;
    assign nif.rs       = D_rs;
    assign nif.epc      = EPC;

    ifu_npc #(
        .EXC_ENTRY (EXC_ENTRY)
    ) u_npc (
        .d          (nif.slave),
        .pc_i       (pc_q),
        .npc_o      (pc_d),
        .eret_sel_o (eret_sel)
    );

    // Req wins over everything; a stall keeps a pending squash alive.
    assign squash_d = Req ? 1'b0 : (_en ? squash_q : eret_sel);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q     <= PC_RESET;
            squash_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            squash_q <= squash_d;
        end
    end

    assign adel        = adel_chk(pc_q, IM_LO, IM_HI);
    assign i_inst_addr = pc_q;
    assign F_PC        = pc_q;

    always_comb begin
        F_IR  = i_inst_rdata;
        F_EXC = EXC_NONE;
        F_BD  = (D_npc_sel != NPC_SEQ);
        if (squash_q) begin
            F_IR = 32'd0;
            F_BD = 1'b0;
        end else if (adel) begin
            F_IR  = 32'd0;
            F_EXC = EXC_ADEL;
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for the fetch unit: reset, sequencing, branches, jumps,
// stalls, exception redirect, eret squash and address error.
module tb_ifu;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;
    logic [31:0] F_PC;
    logic [31:0] F_IR;
    logic [4:0]  F_EXC;
    logic        F_BD;

    int n_chk;
    int n_fail;

    ifu_if dif ();

    ifu dut (
        .clk          (clk),
        .rst          (rst),
        .Req          (dif.req),
        ._en          (dif.en),
        .D_npc_sel    (dif.npc_sel),
        .D_br_taken   (dif.br_taken),
        .D_PC         (dif.d_pc),
        .D_imm16      (dif.imm16),
        .D_imm26      (dif.imm26),
        .D_rs         (dif.rs),
        .D_eret       (dif.eret),
        .EPC          (dif.epc),
        .i_inst_addr  (i_inst_addr),
        .i_inst_rdata (i_inst_rdata),
        .F_PC         (F_PC),
        .F_IR         (F_IR),
        .F_EXC        (F_EXC),
        .F_BD         (F_BD)
    );

    // Instruction memory stand-in: data is a fixed function of address.
    assign i_inst_rdata = i_inst_addr ^ K;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch_ok(input string tag, input logic [31:0] pc);
        check({tag, "_pc"}, F_PC, pc);
        check({tag, "_addr"}, i_inst_addr, pc);
        check({tag, "_exc"}, {27'd0, F_EXC}, 32'd0);
        check({tag, "_ir"}, F_IR, pc ^ K);
    endtask

    task automatic fetch_adel(input string tag, input logic [31:0] pc);
        check({tag, "_pc"}, F_PC, pc);
        check({tag, "_exc"}, {27'd0, F_EXC}, 32'd4);
        check({tag, "_ir"}, F_IR, 32'd0);
    endtask

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        rst          = 1'b0;
        dif.req      = 1'b0;
        dif.en       = 1'b0;
        dif.eret     = 1'b0;
        dif.br_taken = 1'b0;
        dif.npc_sel  = 2'b00;
        dif.d_pc     = 32'd0;
        dif.imm16    = 16'd0;
        dif.imm26    = 26'd0;
        dif.rs       = 32'd0;
        dif.epc      = 32'd0;

        // Reset held for two edges, with Req asserted to show reset wins.
        dif.req = 1'b1;
        step();
        step();
        dif.req = 1'b0;
        fetch_ok("reset", 32'h3000);
        check("reset_bd", {31'd0, F_BD}, 32'd0);
        rst = 1'b1;
        step();
        fetch_ok("seq1", 32'h3004);
        step();
        fetch_ok("seq2", 32'h3008);

        // Reset asserted during a stall restarts at the reset vector.
        dif.en = 1'b1;
        rst    = 1'b0;
        step();
        fetch_ok("rst_stall", 32'h3000);
        rst    = 1'b1;
        dif.en = 1'b0;
        step();
        fetch_ok("pre_br", 32'h3004);

        // Taken branch back by one word: 3000 + 4 - 4.
        dif.d_pc     = 32'h3000;
        dif.npc_sel  = 2'b01;
        dif.br_taken = 1'b1;
        dif.imm16    = 16'hFFFF;
        #1;
        check("br_bd", {31'd0, F_BD}, 32'd1);
        step();
        dif.npc_sel  = 2'b00;
        dif.br_taken = 1'b0;
        #1;
        fetch_ok("br_taken", 32'h3000);
        check("seq_bd", {31'd0, F_BD}, 32'd0);
        step();
        fetch_ok("pre_nt", 32'h3004);

        // Untaken branch still marks the delay slot.
        dif.npc_sel = 2'b01;
        #1;
        check("nt_bd", {31'd0, F_BD}, 32'd1);
        step();
        dif.npc_sel = 2'b00;
        fetch_ok("br_nt", 32'h3008);

        // jr to a misaligned target faults on the next fetch.
        dif.npc_sel = 2'b11;
        dif.rs      = 32'h3002;
        step();
        fetch_adel("jr_mis", 32'h3002);
        check("jr_mis_bd", {31'd0, F_BD}, 32'd1);
        dif.npc_sel = 2'b00;

        // Req overrides a stall on the same edge.
        dif.req = 1'b1;
        dif.en  = 1'b1;
        step();
        dif.req = 1'b0;
        fetch_ok("req_stall", 32'h4180);

        // Stall alone holds pc and ignores a pending jump.
        dif.npc_sel = 2'b10;
        dif.imm26   = 26'h0000123;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold%0d", i), F_PC, 32'h4180);
        end
        dif.en      = 1'b0;
        dif.npc_sel = 2'b00;
        step();
        fetch_ok("unstall", 32'h4184);

        // eret: jump to EPC, kill the following fetch.
        dif.eret = 1'b1;
        dif.epc  = 32'h3010;
        step();
        dif.eret     = 1'b0;
        dif.npc_sel  = 2'b01;
        dif.br_taken = 1'b0;
        #1;
        check("eret_pc", F_PC, 32'h3010);
        check("eret_ir", F_IR, 32'd0);
        check("eret_exc", {27'd0, F_EXC}, 32'd0);
        check("eret_bd", {31'd0, F_BD}, 32'd0);
        step();
        dif.npc_sel = 2'b00;
        fetch_ok("post_eret", 32'h3014);

        // A stall keeps the squash in place.
        dif.eret = 1'b1;
        step();
        dif.eret = 1'b0;
        dif.en   = 1'b1;
        step();
        check("sq_hold_pc", F_PC, 32'h3010);
        check("sq_hold_ir", F_IR, 32'd0);
        dif.en = 1'b0;
        step();
        fetch_ok("sq_rel", 32'h3014);

        // Req on the eret edge wins and leaves no squash.
        dif.eret = 1'b1;
        dif.req  = 1'b1;
        step();
        dif.req = 1'b0;
        fetch_ok("req_eret", 32'h4180);

        // Reset on an eret edge leaves no squash either.
        rst = 1'b0;
        step();
        rst      = 1'b1;
        dif.eret = 1'b0;
        fetch_ok("rst_eret", 32'h3000);

        // jr below the instruction memory.
        dif.npc_sel = 2'b11;
        dif.rs      = 32'h2FFC;
        step();
        dif.npc_sel = 2'b00;
        fetch_adel("below_lo", 32'h2FFC);

        // j near the top, then sequence past the upper bound.
        dif.d_pc    = 32'h3000;
        dif.npc_sel = 2'b10;
        dif.imm26   = 26'h0001BFE;
        step();
        dif.npc_sel = 2'b00;
        fetch_ok("j_tgt", 32'h6FF8);
        step();
        fetch_ok("im_hi", 32'h6FFC);
        step();
        fetch_adel("over_hi", 32'h7000);
        dif.req = 1'b1;
        step();
        dif.req = 1'b0;
        fetch_ok("exc_entry", 32'h4180);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
